burst_collector: RTL and testbench

Parametrised, multi-lane successor to the single-shot burst buffer. After discarding a fixed number of leading samples, it gathers bursts of M samples per lane and publishes each completed burst as a parallel vector with a one-cycle valid pulse. It runs either continuously, with back-to-back bursts and no dead cycles, or one-shot. It sits between a streaming producer such as a line or pixel pipeline and a consumer that needs M-wide parallel windows.

---
 rtl/burst_collector.sv | 124 ++++++++++++
 tb/tb_burst_collector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_collector.sv
// Multi-lane burst collector: skips INITIAL_LATENCY accepted samples, then publishes
// every M accepted samples per lane as one parallel window with a single-cycle valid pulse.
module burst_collector #(
    parameter int INITIAL_LATENCY = 3,
    parameter int M               = 5,
    parameter int PRECISION       = 5,
    parameter int LANES           = 1,
    parameter int REPEAT          = 1
) (
    input  logic                                     clk,
    input  logic                                     clr,
    input  logic                                     ce,
    input  logic                                     in_valid,
    input  logic [LANES-1:0][PRECISION-1:0]          data_in,
    output logic [LANES-1:0][M-1:0][PRECISION-1:0]   data_out,
    output logic                                     out_valid,
    output logic                                     burst_complete,
    output logic [15:0]                              burst_count
);

    localparam int LAT_W    = (INITIAL_LATENCY > 0) ? $clog2(INITIAL_LATENCY + 1) : 1;
    localparam int IDX_W    = (M > 1) ? $clog2(M) : 1;
    localparam int LAT_LAST = (INITIAL_LATENCY > 0) ? INITIAL_LATENCY - 1 : 0;

    typedef enum logic [1:0] {
        ST_LATENCY,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t                                   state_q, state_d;
    logic [LAT_W-1:0]                         lat_cnt_q, lat_cnt_d;
    logic [IDX_W-1:0]                         idx_q, idx_d;
    logic [LANES-1:0][M-1:0][PRECISION-1:0]   shadow_q, shadow_d;
    logic [LANES-1:0][M-1:0][PRECISION-1:0]   data_out_q, data_out_d;
    logic                                     out_valid_q, out_valid_d;
    logic                                     burst_complete_q, burst_complete_d;
    logic [15:0]                              burst_count_q, burst_count_d;
    logic                                     fill_now;

    always_comb begin
        state_d          = state_q;
        lat_cnt_d        = lat_cnt_q;
        idx_d            = idx_q;
        shadow_d         = shadow_q;
        data_out_d       = data_out_q;
        out_valid_d      = 1'b0;
        burst_complete_d = burst_complete_q;
        burst_count_d    = burst_count_q;
        fill_now         = 1'b0;

        if (ce) begin
            case (state_q)
                ST_LATENCY: begin
                    // With no latency the first enabled cycle already behaves as FILL.
                    if (INITIAL_LATENCY == 0) begin
                        state_d  = ST_FILL;
                        fill_now = 1'b1;
                    end else if (in_valid) begin
                        lat_cnt_d = lat_cnt_q + 1'b1;
                        if (lat_cnt_q == LAT_W'(LAT_LAST)) begin
                            state_d = ST_FILL;
                        end
                    end
                end
                ST_FILL: fill_now = 1'b1;
                default: ;
            endcase
        end

        if (fill_now && in_valid) begin
            for (int l = 0; l < LANES; l++) begin
                for (int k = 0; k < M; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        shadow_d[l][k] = data_in[l];
                    end
                end
            end
            if (idx_q == IDX_W'(M - 1)) begin
                for (int l = 0; l < LANES; l++) begin
                    data_out_d[l]        = shadow_q[l];
                    data_out_d[l][M-1]   = data_in[l];
                end
                out_valid_d      = 1'b1;
                burst_complete_d = 1'b1;
                burst_count_d    = burst_count_q + 16'd1;
                idx_d            = '0;
                if (REPEAT == 0) begin
                    state_d = ST_DONE;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q          <= ST_LATENCY;
            lat_cnt_q        <= '0;
            idx_q            <= '0;
            shadow_q         <= '0;
            data_out_q       <= '0;
            out_valid_q      <= 1'b0;
            burst_complete_q <= 1'b0;
            burst_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            lat_cnt_q        <= lat_cnt_d;
            idx_q            <= idx_d;
            shadow_q         <= shadow_d;
            data_out_q       <= data_out_d;
            out_valid_q      <= out_valid_d;
            burst_complete_q <= burst_complete_d;
            burst_count_q    <= burst_count_d;
        end
    end

    assign data_out       = data_out_q;
    assign out_valid      = out_valid_q;
    assign burst_complete = burst_complete_q;
    assign burst_count    = burst_count_q;

endmodule

// File: tb/tb_burst_collector.sv
// Directed bench for burst_collector: default, one-shot, two-lane and M=1 variants
// share one stimulus stream; expectations are hand-computed windows and counts.
module tb_burst_collector;

    typedef struct {
        logic        clr;
        logic        ce;
        logic        iv;
        logic [4:0]  din;
        logic        ev;
        logic [15:0] cnt;
        logic [24:0] dat;
        logic        comp;
    } vec_t;

    logic clk;
    logic clr, ce, in_valid;
    logic [4:0] din5;
    logic [1:0][7:0] lane_in;

    logic [0:0][4:0][4:0] def_out, one_out;
    logic def_valid, def_comp, one_valid, one_comp;
    logic [15:0] def_cnt, one_cnt;

    logic [1:0][4:0][7:0] lane_out;
    logic lane_valid, lane_comp;
    logic [15:0] lane_cnt;

    logic [0:0][0:0][4:0] m1_out;
    logic m1_valid, m1_comp;
    logic [15:0] m1_cnt;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    burst_collector u_def (
        .clk(clk), .clr(clr), .ce(ce), .in_valid(in_valid), .data_in(din5),
        .data_out(def_out), .out_valid(def_valid), .burst_complete(def_comp),
        .burst_count(def_cnt)
    );

    burst_collector #(.REPEAT(0)) u_one (
        .clk(clk), .clr(clr), .ce(ce), .in_valid(in_valid), .data_in(din5),
        .data_out(one_out), .out_valid(one_valid), .burst_complete(one_comp),
        .burst_count(one_cnt)
    );

    burst_collector #(.LANES(2), .PRECISION(8)) u_lane (
        .clk(clk), .clr(clr), .ce(ce), .in_valid(in_valid), .data_in(lane_in),
        .data_out(lane_out), .out_valid(lane_valid), .burst_complete(lane_comp),
        .burst_count(lane_cnt)
    );

    burst_collector #(.INITIAL_LATENCY(0), .M(1)) u_m1 (
        .clk(clk), .clr(clr), .ce(ce), .in_valid(in_valid), .data_in(din5),
        .data_out(m1_out), .out_valid(m1_valid), .burst_complete(m1_comp),
        .burst_count(m1_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] win5(input int b);
        logic [24:0] w;
        for (int k = 0; k < 5; k++) w[k*5 +: 5] = 5'(b + k);
        return w;
    endfunction

    function automatic logic [39:0] win8(input int b);
        logic [39:0] w;
        for (int k = 0; k < 5; k++) w[k*8 +: 8] = 8'(b + k);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic e, input logic v, input int d);
        clr      = c;
        ce       = e;
        in_valid = v;
        din5     = 5'(d);
        lane_in[0] = 8'(d);
        lane_in[1] = 8'(d + 100);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic c, input logic e, input logic v, input int d,
                       input logic ev, input int cnt, input int base, input logic comp);
        vec_t t;
        t.clr  = c;
        t.ce   = e;
        t.iv   = v;
        t.din  = 5'(d);
        t.ev   = ev;
        t.cnt  = 16'(cnt);
        t.dat  = (base < 0) ? '0 : win5(base);
        t.comp = comp;
        tbl.push_back(t);
    endtask

    initial begin
        clk = 1'b0;
        clr = 1'b1; ce = 1'b0; in_valid = 1'b0; din5 = '0; lane_in = '0;

        // Continuous stream 0..12: pulses after samples 7 and 12
        add(1, 0, 0, 0, 0, 0, -1, 0);
        for (int k = 0; k <= 12; k++)
            add(0, 1, 1, k, (k == 7 || k == 12), (k >= 12) ? 2 : (k >= 7) ? 1 : 0,
                (k >= 12) ? 8 : (k >= 7) ? 3 : -1, (k >= 7));

        // in_valid toggling with a 3-cycle ce gap; rejected cycles carry junk 31
        add(1, 0, 0, 0, 0, 0, -1, 0);
        add(0, 1, 1, 0, 0, 0, -1, 0);
        add(0, 1, 0, 31, 0, 0, -1, 0);
        add(0, 1, 1, 1, 0, 0, -1, 0);
        add(0, 1, 0, 31, 0, 0, -1, 0);
        add(0, 1, 1, 2, 0, 0, -1, 0);
        add(0, 1, 0, 31, 0, 0, -1, 0);
        add(0, 1, 1, 3, 0, 0, -1, 0);
        add(0, 1, 0, 31, 0, 0, -1, 0);
        add(0, 1, 1, 4, 0, 0, -1, 0);
        add(0, 0, 1, 31, 0, 0, -1, 0);
        add(0, 0, 1, 31, 0, 0, -1, 0);
        add(0, 0, 1, 31, 0, 0, -1, 0);
        add(0, 1, 1, 5, 0, 0, -1, 0);
        add(0, 1, 0, 31, 0, 0, -1, 0);
        add(0, 1, 1, 6, 0, 0, -1, 0);
        add(0, 1, 0, 31, 0, 0, -1, 0);
        add(0, 1, 1, 7, 1, 1, 3, 1);
        add(0, 1, 0, 31, 0, 1, 3, 1);
        add(0, 1, 1, 8, 0, 1, 3, 1);
        add(0, 1, 0, 31, 0, 1, 3, 1);
        add(0, 1, 1, 9, 0, 1, 3, 1);
        add(0, 1, 0, 31, 0, 1, 3, 1);
        add(0, 1, 1, 10, 0, 1, 3, 1);
        add(0, 1, 0, 31, 0, 1, 3, 1);
        add(0, 1, 1, 11, 0, 1, 3, 1);
        add(0, 1, 0, 31, 0, 1, 3, 1);
        add(0, 1, 1, 12, 1, 2, 8, 1);
        add(0, 0, 1, 31, 0, 2, 8, 1);
        add(0, 1, 1, 13, 0, 2, 8, 1);

        // clr mid-burst, fresh latency afterwards, then clr on the burst-end accept
        add(1, 0, 0, 0, 0, 0, -1, 0);
        for (int k = 0; k <= 4; k++) add(0, 1, 1, k, 0, 0, -1, 0);
        add(1, 1, 1, 5, 0, 0, -1, 0);
        for (int k = 20; k <= 26; k++) add(0, 1, 1, k, 0, 0, -1, 0);
        add(0, 1, 1, 27, 1, 1, 23, 1);
        add(1, 1, 1, 0, 0, 0, -1, 0);
        for (int k = 0; k <= 6; k++) add(0, 1, 1, k, 0, 0, -1, 0);
        add(1, 1, 1, 7, 0, 0, -1, 0);
        add(0, 1, 1, 9, 0, 0, -1, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].clr, tbl[i].ce, tbl[i].iv, int'(tbl[i].din));
            chk($sformatf("v%0d valid", i), 64'(def_valid), 64'(tbl[i].ev));
            chk($sformatf("v%0d count", i), 64'(def_cnt),   64'(tbl[i].cnt));
            chk($sformatf("v%0d data", i),  64'(def_out),   64'(tbl[i].dat));
            chk($sformatf("v%0d done", i),  64'(def_comp),  64'(tbl[i].comp));
        end

        // One-shot and two-lane variants on a continuous stream 0..27
        cyc(1, 0, 0, 0);
        chk("one reset data", 64'(one_out), 64'(0));
        chk("lane reset data", 64'(lane_out[1]), 64'(0));
        for (int k = 0; k <= 27; k++) begin
            cyc(0, 1, 1, k);
            if (k < 7) begin
                chk($sformatf("one k%0d valid", k), 64'(one_valid), 64'(0));
                chk($sformatf("lane k%0d valid", k), 64'(lane_valid), 64'(0));
            end else if (k == 7) begin
                chk("one first valid", 64'(one_valid), 64'(1));
                chk("one first data", 64'(one_out), 64'(win5(3)));
                chk("lane first valid", 64'(lane_valid), 64'(1));
                chk("lane0 first data", 64'(lane_out[0]), 64'(win8(3)));
                chk("lane1 first data", 64'(lane_out[1]), 64'(win8(103)));
                chk("lane first count", 64'(lane_cnt), 64'(1));
            end else begin
                chk($sformatf("one k%0d valid", k), 64'(one_valid), 64'(0));
                chk($sformatf("one k%0d data", k), 64'(one_out), 64'(win5(3)));
                chk($sformatf("one k%0d count", k), 64'(one_cnt), 64'(1));
                chk($sformatf("one k%0d done", k), 64'(one_comp), 64'(1));
            end
            if (k == 12) begin
                chk("lane second valid", 64'(lane_valid), 64'(1));
                chk("lane0 second data", 64'(lane_out[0]), 64'(win8(8)));
                chk("lane1 second data", 64'(lane_out[1]), 64'(win8(108)));
                chk("lane second count", 64'(lane_cnt), 64'(2));
                chk("lane done", 64'(lane_comp), 64'(1));
            end
        end

        // No latency, M=1: a pulse per accept and a counter wrap after 65536 bursts
        cyc(1, 0, 0, 0);
        chk("m1 reset valid", 64'(m1_valid), 64'(0));
        chk("m1 reset count", 64'(m1_cnt), 64'(0));
        for (int n = 0; n < 65536; n++) begin
            cyc(0, 1, 1, (n * 7 + 3) % 32);
            if (n < 20) begin
                chk($sformatf("m1 n%0d valid", n), 64'(m1_valid), 64'(1));
                chk($sformatf("m1 n%0d data", n), 64'(m1_out), 64'((n * 7 + 3) % 32));
                chk($sformatf("m1 n%0d count", n), 64'(m1_cnt), 64'(n + 1));
            end else if (n == 65534) begin
                chk("m1 count max", 64'(m1_cnt), 64'(16'hFFFF));
            end else if (n == 65535) begin
                chk("m1 count wrap", 64'(m1_cnt), 64'(0));
                chk("m1 done after wrap", 64'(m1_comp), 64'(1));
                chk("m1 valid at wrap", 64'(m1_valid), 64'(1));
            end
        end
        cyc(0, 0, 1, 5);
        chk("m1 valid ce low", 64'(m1_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
